// File: rtl/y_run_length_reporter.sv
// y_run_length_reporter
// Measures the length of each completed high run of the upstream Y signal,
// queues {length, saturated} records in a small FIFO, and drains them over a
// valid/ready interface. Also reports dropped records and run-in-progress.
module y_run_length_reporter #(
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DROP_W     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          y_in,
   input  logic                          en,
   input  logic                          rec_ready,
   output logic                          rec_valid,
   output logic [LEN_W-1:0]              rec_len,
   output logic                          rec_sat,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [DROP_W-1:0]             drop_cnt,
   output logic                          busy
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {IDLE, RUN} state_t;

   // Saturating increment helpers for the run-length and drop counters.
   function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
      return (v == {LEN_W{1'b1}}) ? v : v + LEN_W'(1);
   endfunction

   function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
      return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
   endfunction

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   run_cnt_q, run_cnt_d;
   logic               sat_q, sat_d;
   logic               push;

   logic [LEN_W:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic [DROP_W-1:0]  drop_q;
   logic               full, pop, wr_ok, drop;

   // Run FSM register: state, run counter and saturation flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         run_cnt_q <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
         sat_q     <= sat_d;
      end
   end

   // Run FSM next state: measure a high run, emit a record on the falling sample.
   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      sat_d     = sat_q;
      push      = 1'b0;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (y_in) begin
                  state_d   = RUN;
                  run_cnt_d = LEN_W'(1);
                  sat_d     = 1'b0;
               end
            end
            RUN: begin
               if (y_in) begin
                  run_cnt_d = sat_inc_len(run_cnt_q);
                  if (run_cnt_q == {LEN_W{1'b1}}) sat_d = 1'b1;
               end else begin
                  push      = 1'b1;
                  state_d   = IDLE;
                  run_cnt_d = '0;
                  sat_d     = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop   = rec_valid && rec_ready;
   assign wr_ok = push && (!full || pop);
   assign drop  = push && full && !pop;

   // Record storage; payload only, so no reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr_q] <= {run_cnt_q, sat_q};
   end

   // FIFO pointers, occupancy and saturating drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({wr_ok, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
         if (drop) drop_q <= sat_inc_drop(drop_q);
      end
   end

   assign rec_valid  = (level_q != '0);
   assign rec_len    = rec_valid ? mem[rd_ptr_q][LEN_W:1] : '0;
   assign rec_sat    = rec_valid ? mem[rd_ptr_q][0] : 1'b0;
   assign fifo_level = level_q;
   assign drop_cnt   = drop_q;
   assign busy       = (state_q == RUN);

endmodule

// File: tb/tb_y_run_length_reporter.sv
// Directed bench for y_run_length_reporter with hand-computed expectations.
module tb_y_run_length_reporter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       y_in;
   logic       en;
   logic       rec_ready;
   logic       rec_valid;
   logic [7:0] rec_len;
   logic       rec_sat;
   logic [2:0] fifo_level;
   logic [7:0] drop_cnt;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;

   y_run_length_reporter #(.LEN_W(8), .FIFO_DEPTH(4), .DROP_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .y_in(y_in), .en(en), .rec_ready(rec_ready),
      .rec_valid(rec_valid), .rec_len(rec_len), .rec_sat(rec_sat),
      .fifo_level(fifo_level), .drop_cnt(drop_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive y_in, advance one rising edge, settle 1 time unit.
   task automatic cyc(input logic y);
      y_in = y;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; y_in = 1'b0; en = 1'b0; rec_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", rec_valid, 0);
      chk("rst_len",   rec_len, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_drop",  drop_cnt, 0);
      chk("rst_busy",  busy, 0);
      rst_n = 1'b1;
      cyc(0);
      chk("rel_valid", rec_valid, 0);
      chk("rel_busy",  busy, 0);

      // Basic run of 3 with consumer ready
      en = 1'b1; rec_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("r3_busy", busy, 1);
         chk("r3_novalid", rec_valid, 0);
      end
      cyc(0);
      chk("r3_valid", rec_valid, 1);
      chk("r3_len",   rec_len, 3);
      chk("r3_sat",   rec_sat, 0);
      chk("r3_level", fifo_level, 1);
      chk("r3_busy0", busy, 0);
      cyc(0);
      chk("r3_popped", fifo_level, 0);
      chk("r3_valid0", rec_valid, 0);
      chk("r3_len0",   rec_len, 0);

      // Saturating run of 300
      for (int i = 0; i < 300; i++) cyc(1);
      chk("s_busy", busy, 1);
      cyc(0);
      chk("s_len",  rec_len, 255);
      chk("s_sat",  rec_sat, 1);
      chk("s_drop", drop_cnt, 0);
      cyc(0);
      chk("s_level0", fifo_level, 0);

      // Runs 1..5 with consumer stalled: fifth dropped
      rec_ready = 1'b0;
      for (int l = 1; l <= 5; l++) begin
         for (int i = 0; i < l; i++) cyc(1);
         cyc(0);
      end
      chk("f_level", fifo_level, 4);
      chk("f_drop",  drop_cnt, 1);
      chk("f_head",  rec_len, 1);
      rec_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("f_order", rec_len, k);
         chk("f_sat", rec_sat, 0);
         cyc(0);
         chk("f_lvl", fifo_level, 4 - k);
      end
      chk("f_empty", rec_valid, 0);

      // Full FIFO, push and pop on the same edge
      rec_ready = 1'b0;
      for (int l = 7; l <= 10; l++) begin
         for (int i = 0; i < l; i++) cyc(1);
         cyc(0);
      end
      chk("pp_full", fifo_level, 4);
      for (int i = 0; i < 6; i++) cyc(1);
      chk("pp_stable", rec_len, 7);
      rec_ready = 1'b1;
      cyc(0);
      chk("pp_level", fifo_level, 4);
      chk("pp_drop",  drop_cnt, 1);
      chk("pp_head",  rec_len, 8);
      chk("pp_o8",  rec_len, 8);  cyc(0);
      chk("pp_o9",  rec_len, 9);  cyc(0);
      chk("pp_o10", rec_len, 10); cyc(0);
      chk("pp_o6",  rec_len, 6);  cyc(0);
      chk("pp_empty", fifo_level, 0);

      // en=0 freezes measurement
      cyc(1); cyc(1);
      en = 1'b0;
      cyc(1); cyc(0); cyc(1);
      chk("en_busy",  busy, 1);
      chk("en_level", fifo_level, 0);
      en = 1'b1;
      cyc(1); cyc(1);
      cyc(0);
      chk("en_len",   rec_len, 4);
      chk("en_level1", fifo_level, 1);
      cyc(0);
      chk("en_level0", fifo_level, 0);

      // Drop counter saturation
      rec_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin cyc(1); cyc(0); end
      for (int i = 0; i < 300; i++) begin cyc(1); cyc(0); end
      chk("ds_drop",  drop_cnt, 255);
      chk("ds_level", fifo_level, 4);

      // Reset mid-run with a queued record and nonzero drop count
      rec_ready = 1'b1;
      for (int i = 0; i < 5; i++) cyc(0);
      rec_ready = 1'b0;
      cyc(1); cyc(1); cyc(0);
      for (int i = 0; i < 5; i++) cyc(1);
      chk("mr_busy1",  busy, 1);
      chk("mr_level1", fifo_level, 1);
      rst_n = 1'b0;
      #2;
      chk("mr_busy",  busy, 0);
      chk("mr_valid", rec_valid, 0);
      chk("mr_level", fifo_level, 0);
      chk("mr_drop",  drop_cnt, 0);
      rst_n = 1'b1;
      cyc(0);
      cyc(0);
      chk("mr_norec", rec_valid, 0);
      chk("mr_nobusy", busy, 0);
      chk("mr_lvl0", fifo_level, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/y_run_length_reporter.md
Name: y_run_length_reporter

Overview:
Sits directly downstream of the C/Y sequence-detector FSM and consumes its single-bit Y output. It measures the length of every completed high run of Y, in sampled cycles, and queues each result as a record. Records go to a small FIFO and drain over a valid/ready interface toward a status/CSR collector. The block also reports drops, saturation and run-in-progress status.

Parameters:
LEN_W, 8, width of run-length counter and rec_len; saturates at 2^LEN_W-1
FIFO_DEPTH, 4, record FIFO entries; power of 2, >=2
DROP_W, 8, width of saturating dropped-record counter

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
y_in  input  1  Y from upstream sequence detector
en  input  1  sample enable; 0 freezes run measurement
rec_ready  input  1  consumer accepts head record
rec_valid  output  1  FIFO non-empty
rec_len  output  LEN_W  head record run length
rec_sat  output  1  head record length saturated
fifo_level  output  clog2(FIFO_DEPTH)+1  stored record count
drop_cnt  output  DROP_W  records lost to full FIFO, saturating
busy  output  1  high run in progress (FSM in RUN)

Behaviour:
- Reset: async on rst_n low, sync release. FSM->IDLE, run_cnt=0, sat flag=0, FIFO empty, rd/wr pointers 0, drop_cnt=0. All outputs 0 while reset is asserted and after release.
- Sampling: y_in sampled on each rising edge with en=1. With en=0, FSM, run_cnt and sat flag hold; FIFO pop still operates.
- FSM IDLE: sample y_in=1 -> RUN, run_cnt=1, sat=0. Sample y_in=0 -> stay IDLE.
- FSM RUN: sample y_in=1 -> stay RUN. If run_cnt<2^LEN_W-1, increment run_cnt. Otherwise hold run_cnt and set sat=1.
- FSM RUN, sample y_in=0 -> push {run_cnt, sat} on the same edge, go to IDLE, clear run_cnt to 0.
- busy = (state==RUN).
- Minimum run is 1: one high sample followed by a low sample gives len=1.
- Push latency: the record is written on the edge that samples the terminating 0. rec_valid is high from that edge onward; it is a registered level and 0 cycles after that edge.
- rec_valid = (fifo_level!=0). rec_len/rec_sat show the head entry and read 0 when empty.
- Pop occurs on an edge where rec_valid && rec_ready. Head outputs stay stable while rec_valid && !rec_ready. Records leave in arrival order.
- Push while full, no pop: the record is dropped, level unchanged, drop_cnt increments and saturates at 2^DROP_W-1.
- Push while full with pop on the same edge: the pop frees the slot and the push is accepted. Level stays FIFO_DEPTH; no drop.
- Push and pop together when not full: level unchanged.
- Pop while empty (rec_ready=1, rec_valid=0): no effect.
- Pointers wrap modulo FIFO_DEPTH. fifo_level never exceeds FIFO_DEPTH.
- Reset mid-run: the partial run is discarded and no record is produced. Queued records are lost.

Test Plan:
- Reset, rec_ready=1, en=1. y_in high 3 samples then low -> rec_valid high 1 cycle with rec_len=3, rec_sat=0. busy high 3 cycles. fifo_level 1->0.
- LEN_W=8: y_in high 300 samples then low -> rec_len=255, rec_sat=1, drop_cnt=0.
- rec_ready=0, runs of length 1,2,3,4,5 separated by one low sample -> fifo_level=4, drop_cnt=1. Then rec_ready=1 -> pops len 1,2,3,4 in order and level returns to 0.
- FIFO full (4). On the same edge, a run of 6 terminates and rec_ready=1 -> level stays 4, drop_cnt unchanged. The newest entry, len=6, emerges after the other 3.
- y_in high 2 samples, en=0 for 3 cycles with y_in toggling, en=1, y_in high 2 more samples then low -> single record len=4.
- Mid-run (5 high samples, busy=1), pulse rst_n low between clock edges -> busy, rec_valid, fifo_level and drop_cnt go 0 immediately. After release, y_in low produces no record.
